// File: rtl/multi_edge_pulse_gen_pkg.sv
// Shared definitions for the multi-channel edge-to-pulse generator.
// Edge mode encodings (2 bits per channel) and the edge-qualify helper.
`timescale 1ns/1ps
package multi_edge_pulse_gen_pkg;

    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_BOTH = 2'b10;
    localparam logic [1:0] EDGE_OFF  = 2'b11;

    // True when the synchronised level and its previous value form an edge
    // of the kind selected by mode.
    function automatic logic edge_hit(input logic [1:0] mode,
                                      input logic       sync_lvl,
                                      input logic       prev_lvl);
        logic hit;
        hit = 1'b0;
        case (mode)
            EDGE_RISE: hit = sync_lvl & ~prev_lvl;
            EDGE_FALL: hit = ~sync_lvl & prev_lvl;
            EDGE_BOTH: hit = sync_lvl ^ prev_lvl;
            EDGE_OFF:  hit = 1'b0;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/multi_edge_pulse_gen_if.sv
// Bus bundle for multi_edge_pulse_gen.
//   lvl_sig   : async level inputs, one per channel
//   edge_mode : per-channel mode, channel i uses [2i+1:2i]
//   pulse_len : pulse length minus one, shared by all channels
//   evt_clr   : synchronous clear of sticky event flags
//   pulse_sig : registered output pulses
//   evt_flag  : sticky edge-seen flags
//   any_pulse : registered OR of all channel pulses
// master drives the controls (software/testbench side), slave is the generator.
`timescale 1ns/1ps
interface multi_edge_pulse_gen_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned PW_W   = 4
);
    logic [NUM_CH-1:0]   lvl_sig;
    logic [2*NUM_CH-1:0] edge_mode;
    logic [PW_W-1:0]     pulse_len;
    logic [NUM_CH-1:0]   evt_clr;
    logic [NUM_CH-1:0]   pulse_sig;
    logic [NUM_CH-1:0]   evt_flag;
    logic                any_pulse;

    modport master (
        output lvl_sig, edge_mode, pulse_len, evt_clr,
        input  pulse_sig, evt_flag, any_pulse
    );

    modport slave (
        input  lvl_sig, edge_mode, pulse_len, evt_clr,
        output pulse_sig, evt_flag, any_pulse
    );
endinterface

// File: rtl/multi_edge_pulse_gen_edge_pulse_ch.sv
// One channel of the edge-to-pulse generator.
//   CLK, RST  : destination clock, async active-low reset
//   lvl_in    : asynchronous level input
//   mode      : edge select (rise/fall/both/off)
//   pulse_len : pulse length minus one, captured at trigger
//   evt_clr   : clear for the sticky event flag
//   pulse_out : registered pulse
//   pulse_nxt : next-state value of pulse_out (for the shared any_pulse register)
//   evt_out   : sticky edge-seen flag
`timescale 1ns/1ps
module edge_pulse_ch
    import multi_edge_pulse_gen_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PW_W        = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            lvl_in,
    input  logic [1:0]      mode,
    input  logic [PW_W-1:0] pulse_len,
    input  logic            evt_clr,
    output logic            pulse_out,
    output logic            pulse_nxt,
    output logic            evt_out
);

    localparam logic [PW_W-1:0] CNT_ONE = PW_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [PW_W-1:0]        cnt_q;
    logic [PW_W-1:0]        cnt_d;
    logic                   pulse_q;
    logic                   pulse_d;
    logic                   evt_q;
    logic                   evt_d;
    logic                   sync_lvl;
    logic                   trigger;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_comb begin
        trigger = edge_hit(mode, sync_lvl, prev_q);
        pulse_d = pulse_q;
        cnt_d   = cnt_q;
        evt_d   = evt_q;
        // A trigger always reloads, including on the pulse's last cycle,
        // so retriggers extend the pulse without a low gap.
        if (trigger) begin
            pulse_d = 1'b1;
            cnt_d   = pulse_len;
        end else if (pulse_q) begin
            if (cnt_q == '0) begin
                pulse_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
        // Set has priority over clear.
        if (trigger) begin
            evt_d = 1'b1;
        end else if (evt_clr) begin
            evt_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], lvl_in};
            prev_q  <= sync_lvl;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            evt_q   <= evt_d;
        end
    end

    assign pulse_out = pulse_q;
    assign pulse_nxt = pulse_d;
    assign evt_out   = evt_q;

endmodule

// File: rtl/multi_edge_pulse_gen.sv
// Multi-channel edge-to-pulse generator: NUM_CH independent channels, each
// synchronising a level input, detecting the selected edge and emitting a
// retriggerable pulse of pulse_len+1 cycles, plus a sticky event flag.
//   CLK : destination-domain clock
//   RST : asynchronous active-low reset
//   bus : multi_edge_pulse_gen_if slave (lvl_sig, edge_mode, pulse_len,
//         evt_clr in; pulse_sig, evt_flag, any_pulse out)
`timescale 1ns/1ps
module multi_edge_pulse_gen
    import multi_edge_pulse_gen_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PW_W        = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    multi_edge_pulse_gen_if.slave   bus
);

    logic [NUM_CH-1:0] pulse_w;
    logic [NUM_CH-1:0] pulse_nxt_w;
    logic [NUM_CH-1:0] evt_w;
    logic              any_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        edge_pulse_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .PW_W        (PW_W)
        ) u_ch (
            .CLK       (CLK),
            .RST       (RST),
            .lvl_in    (bus.lvl_sig[i]),
            .mode      (bus.edge_mode[2*i +: 2]),
            .pulse_len (bus.pulse_len),
            .evt_clr   (bus.evt_clr[i]),
            .pulse_out (pulse_w[i]),
            .pulse_nxt (pulse_nxt_w[i]),
            .evt_out   (evt_w[i])
        );
    end

    // Registering the OR of next-state bits keeps any_pulse cycle-aligned
    // with pulse_sig while leaving no combinational output path.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |pulse_nxt_w;
        end
    end

    assign bus.pulse_sig = pulse_w;
    assign bus.evt_flag  = evt_w;
    assign bus.any_pulse = any_q;

endmodule

// File: tb/tb_multi_edge_pulse_gen.sv
// Directed bench for multi_edge_pulse_gen with a cycle model feeding a
// scoreboard queue of expected outputs.
`timescale 1ns/1ps
module tb_multi_edge_pulse_gen;

    localparam int NCH = 4;
    localparam int SS  = 2;

    typedef struct {
        logic [NCH-1:0] pulse;
        logic [NCH-1:0] evt;
        logic           any;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];

    // reference model state: remaining high cycles per channel
    logic [SS-1:0] m_sync [NCH];
    logic          m_prev [NCH];
    int            m_rem  [NCH];
    logic          m_evt  [NCH];

    int            hi_cnt   [NCH];
    int            rise_cnt [NCH];
    logic [NCH-1:0] last_p;

    always #5 CLK = ~CLK;

    multi_edge_pulse_gen_if #(.NUM_CH(NCH), .PW_W(4)) pif ();

    multi_edge_pulse_gen #(
        .NUM_CH      (NCH),
        .SYNC_STAGES (SS),
        .PW_W        (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (pif)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_sync[c] = '0;
            m_prev[c] = 1'b0;
            m_rem[c]  = 0;
            m_evt[c]  = 1'b0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic s, p, trig;
        logic [1:0] md;
        if (!RST) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            s  = m_sync[c][SS-1];
            p  = m_prev[c];
            md = pif.edge_mode[2*c +: 2];
            case (md)
                2'b00:   trig = s && !p;
                2'b01:   trig = !s && p;
                2'b10:   trig = (s != p);
                default: trig = 1'b0;
            endcase
            if (trig)            m_rem[c] = int'(pif.pulse_len) + 1;
            else if (m_rem[c] > 0) m_rem[c] = m_rem[c] - 1;
            if (trig)                 m_evt[c] = 1'b1;
            else if (pif.evt_clr[c])  m_evt[c] = 1'b0;
            m_prev[c] = s;
            m_sync[c] = {m_sync[c][SS-2:0], pif.lvl_sig[c]};
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        for (int c = 0; c < NCH; c++) begin
            e.pulse[c] = (m_rem[c] > 0);
            e.evt[c]   = m_evt[c];
        end
        e.any = |e.pulse;
        return e;
    endfunction

    task automatic clear_counts();
        for (int c = 0; c < NCH; c++) begin
            hi_cnt[c]   = 0;
            rise_cnt[c] = 0;
        end
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        exp_q.push_back(model_out());
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        chk("pulse_sig", 32'(pif.pulse_sig), 32'(e.pulse));
        chk("evt_flag",  32'(pif.evt_flag),  32'(e.evt));
        chk("any_pulse", 32'(pif.any_pulse), 32'(e.any));
        for (int c = 0; c < NCH; c++) begin
            if (pif.pulse_sig[c] === 1'b1) begin
                hi_cnt[c]++;
                if (last_p[c] !== 1'b1) rise_cnt[c]++;
            end
            last_p[c] = pif.pulse_sig[c];
        end
    endtask

    initial begin
        last_p = '0;
        clear_counts();
        RST               = 1'b0;
        pif.lvl_sig       = 4'b0001;
        pif.edge_mode     = 8'h00;
        pif.pulse_len     = 4'd0;
        pif.evt_clr       = 4'b0000;
        model_reset();

        // reset state
        step();
        step();
        chk("reset_pulse", 32'(pif.pulse_sig), 32'h0);
        chk("reset_evt",   32'(pif.evt_flag),  32'h0);
        chk("reset_any",   32'(pif.any_pulse), 32'h0);

        // 1: ch0 high at release -> rising edge, 1-cycle pulse
        RST = 1'b1;
        clear_counts();
        step();
        step();
        chk("t1_not_yet", 32'(pif.pulse_sig), 32'h0);
        step();
        chk("t1_pulse_on", 32'(pif.pulse_sig), 32'h1);
        repeat (4) step();
        chk("t1_len0", 32'(hi_cnt[0]), 32'd1);
        chk("t1_others", 32'(hi_cnt[1] + hi_cnt[2] + hi_cnt[3]), 32'd0);

        // 2: ch1 falling edge, len 3 -> 4-cycle pulse, sticky flag
        pif.edge_mode = 8'b00_00_01_00;
        pif.pulse_len = 4'd3;
        pif.lvl_sig[1] = 1'b1;
        repeat (4) step();
        clear_counts();
        pif.lvl_sig[1] = 1'b0;
        repeat (10) step();
        chk("t2_len", 32'(hi_cnt[1]), 32'd4);
        chk("t2_evt_set", 32'(pif.evt_flag[1]), 32'd1);
        pif.evt_clr[1] = 1'b1;
        step();
        pif.evt_clr[1] = 1'b0;
        chk("t2_evt_clr", 32'(pif.evt_flag[1]), 32'd0);

        // 3: ch2 both edges, len 5, toggles every 3 cycles -> one 15-cycle pulse
        pif.edge_mode[5:4] = 2'b10;
        pif.pulse_len = 4'd5;
        clear_counts();
        for (int k = 0; k < 4; k++) begin
            pif.lvl_sig[2] = ~pif.lvl_sig[2];
            repeat (3) step();
        end
        repeat (20) step();
        chk("t3_len", 32'(hi_cnt[2]), 32'd15);
        chk("t3_one_pulse", 32'(rise_cnt[2]), 32'd1);

        // 4: ch3 disabled while toggling; ch0 mode switched mid-pulse
        pif.edge_mode[7:6] = 2'b11;
        clear_counts();
        for (int k = 0; k < 4; k++) begin
            pif.lvl_sig[3] = ~pif.lvl_sig[3];
            repeat (2) step();
        end
        repeat (4) step();
        chk("t4_off_pulse", 32'(hi_cnt[3]), 32'd0);
        chk("t4_off_evt", 32'(pif.evt_flag[3]), 32'd0);
        pif.edge_mode[1:0] = 2'b10;
        pif.pulse_len = 4'd4;
        clear_counts();
        pif.lvl_sig[0] = 1'b0;
        repeat (4) step();
        pif.edge_mode[1:0] = 2'b00;
        repeat (8) step();
        chk("t4_mode_sw_len", 32'(hi_cnt[0]), 32'd5);

        // 5: evt_clr coincident with a ch0 trigger -> flag stays set
        pif.evt_clr[0] = 1'b1;
        step();
        pif.evt_clr[0] = 1'b0;
        chk("t5_pre_clr", 32'(pif.evt_flag[0]), 32'd0);
        pif.lvl_sig[0] = 1'b1;
        step();
        step();
        pif.evt_clr[0] = 1'b1;
        step();
        pif.evt_clr[0] = 1'b0;
        chk("t5_set_wins", 32'(pif.evt_flag[0]), 32'd1);
        chk("t5_pulse", 32'(pif.pulse_sig[0]), 32'd1);
        repeat (6) step();

        // 6: pulse_len changed mid-pulse, then a fresh trigger uses the new length
        pif.edge_mode[3:2] = 2'b00;
        pif.pulse_len = 4'd7;
        clear_counts();
        pif.lvl_sig[1] = 1'b1;
        repeat (4) step();
        pif.pulse_len = 4'd1;
        repeat (10) step();
        chk("t6_len_held", 32'(hi_cnt[1]), 32'd8);
        pif.lvl_sig[1] = 1'b0;
        repeat (3) step();
        clear_counts();
        pif.lvl_sig[1] = 1'b1;
        repeat (6) step();
        chk("t6_len_new", 32'(hi_cnt[1]), 32'd2);

        // async reset in the middle of a ch2 pulse
        pif.pulse_len = 4'd5;
        pif.lvl_sig[2] = ~pif.lvl_sig[2];
        repeat (4) step();
        chk("t7_pre_rst", 32'(pif.pulse_sig[2]), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        chk("t7_rst_pulse", 32'(pif.pulse_sig), 32'h0);
        chk("t7_rst_evt",   32'(pif.evt_flag),  32'h0);
        chk("t7_rst_any",   32'(pif.any_pulse), 32'h0);
        model_reset();
        step();
        step();
        RST = 1'b1;
        repeat (8) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
